// File: rtl/mmult_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : mmult_param_if
//  Purpose  : Start/operand/result bundle for the N x N matrix multiplier.
//  Revision : 1.0  initial release
// ============================================================================
interface mmult_param_if #(
    parameter int N  = 4,
    parameter int DW = 8
);
    localparam int OW = 2*DW + $clog2(N);

    logic                  enable;
    logic [0:N*N*DW-1]     A_mat;
    logic [0:N*N*DW-1]     B_mat;
    logic                  valid;
    logic                  busy;
    logic [0:N*N*OW-1]     result;

    modport master (
        output enable, A_mat, B_mat,
        input  valid, busy, result
    );

    modport slave (
        input  enable, A_mat, B_mat,
        output valid, busy, result
    );
endinterface
`default_nettype wire

// File: rtl/mmult_param.sv
`default_nettype none
// ============================================================================
//  Module   : mmult_param
//  Purpose  : Sequential N x N matrix multiplier, one result entry per cycle
//             using N parallel multipliers feeding an adder tree.
//  Revision : 1.0  initial release
// ============================================================================
module mmult_param #(
    parameter int N      = 4,
    parameter int DW     = 8,
    parameter int SIGNED = 0
) (
    input  logic         clk,
    input  logic         reset,
    mmult_param_if.slave bus
);
    localparam int OW  = 2*DW + $clog2(N);
    localparam int NN  = N*N;
    localparam int IW  = $clog2(NN);
    localparam int LVL = $clog2(N);
    localparam int P   = 1 << LVL;
    localparam int PRW = 2*DW + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [0:NN*DW-1]  a_q, a_d;
    logic [0:NN*DW-1]  b_q, b_d;
    logic [0:NN*OW-1]  result_q, result_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;

    int                w_row;
    int                w_col;
    logic signed [OW-1:0] w_sum;

    always_comb begin
        w_row = int'(idx_q) / N;
        w_col = int'(idx_q) % N;
    end

    // Level 0 holds the N products (padded to a power of two); each higher
    // level halves the node count until a single sum remains.
    generate
        for (genvar l = 0; l <= LVL; l++) begin : g_lvl
            logic signed [OW-1:0] node [0:(P>>l)-1];
            for (genvar n = 0; n < (P>>l); n++) begin : g_node
                if (l == 0) begin : g_leaf
                    if (n < N) begin : g_mul
                        logic signed [DW:0]    w_a_sx;
                        logic signed [DW:0]    w_b_sx;
                        logic signed [PRW-1:0] w_prod;
                        always_comb begin
                            w_a_sx = {(SIGNED != 0) && a_q[(w_row*N + n)*DW],
                                      a_q[(w_row*N + n)*DW +: DW]};
                            w_b_sx = {(SIGNED != 0) && b_q[(n*N + w_col)*DW],
                                      b_q[(n*N + w_col)*DW +: DW]};
                            w_prod = PRW'(w_a_sx) * PRW'(w_b_sx);
                        end
                        // Product always fits in 2*DW+1 signed bits, so
                        // resizing to OW keeps the value exact.
                        assign node[n] = OW'(w_prod);
                    end else begin : g_pad
                        assign node[n] = '0;
                    end
                end else begin : g_add
                    assign node[n] = g_lvl[l-1].node[2*n] + g_lvl[l-1].node[2*n+1];
                end
            end
        end
    endgenerate

    assign w_sum = g_lvl[LVL].node[0];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        valid_d  = 1'b0;
        busy_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.enable) begin
                    a_d     = bus.A_mat;
                    b_d     = bus.B_mat;
                    idx_d   = '0;
                    state_d = S_CALC;
                    busy_d  = 1'b1;
                end
            end
            S_CALC: begin
                result_d[int'(idx_q)*OW +: OW] = w_sum;
                if (idx_q == IW'(NN-1)) begin
                    idx_d   = '0;
                    state_d = S_DONE;
                    valid_d = 1'b1;
                end else begin
                    idx_d   = idx_q + IW'(1);
                    busy_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.valid  = valid_q;
    assign bus.busy   = busy_q;
    assign bus.result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_mmult_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mmult_param
//  Purpose  : Directed vector bench for three mmult_param configurations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mmult_param;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mmult_param_if #(.N(4), .DW(8)) if0 ();
    mmult_param_if #(.N(4), .DW(8)) if1 ();
    mmult_param_if #(.N(2), .DW(4)) if2 ();

    mmult_param #(.N(4), .DW(8), .SIGNED(0)) u_dut0 (.clk(clk), .reset(reset), .bus(if0));
    mmult_param #(.N(4), .DW(8), .SIGNED(1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));
    mmult_param #(.N(2), .DW(4), .SIGNED(0)) u_dut2 (.clk(clk), .reset(reset), .bus(if2));

    typedef struct {
        string name;
        int    inst;
        int    lat;
        int    a [16];
        int    b [16];
        int    c [16];
    } vec_t;

    localparam int NVEC = 9;
    vec_t tbl [NVEC];

    function automatic int nn_of(int inst);
        return (inst == 2) ? 4 : 16;
    endfunction

    function automatic int ow_of(int inst);
        return (inst == 2) ? 9 : 18;
    endfunction

    function automatic logic get_valid(int inst);
        case (inst)
            0:       return if0.valid;
            1:       return if1.valid;
            default: return if2.valid;
        endcase
    endfunction

    function automatic logic get_busy(int inst);
        case (inst)
            0:       return if0.busy;
            1:       return if1.busy;
            default: return if2.busy;
        endcase
    endfunction

    function automatic int get_res(int inst, int e);
        case (inst)
            0:       return int'(if0.result[e*18 +: 18]);
            1:       return int'(if1.result[e*18 +: 18]);
            default: return int'(if2.result[e*9 +: 9]);
        endcase
    endfunction

    task automatic check(string name, int got, int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic check_res(string name, int inst, int c [16]);
        int bad;
        int mask;
        bad  = -1;
        mask = (1 << ow_of(inst)) - 1;
        for (int e = 0; e < nn_of(inst); e++)
            if (bad < 0 && get_res(inst, e) != (c[e] & mask)) bad = e;
        if (bad < 0) bad = 0;
        check($sformatf("%s result[%0d]", name, bad), get_res(inst, bad), c[bad] & mask);
    endtask

    task automatic drive(vec_t v);
        for (int e = 0; e < 16; e++) begin
            if (v.inst == 0) begin
                if0.A_mat[e*8 +: 8] = 8'(v.a[e]);
                if0.B_mat[e*8 +: 8] = 8'(v.b[e]);
            end else if (v.inst == 1) begin
                if1.A_mat[e*8 +: 8] = 8'(v.a[e]);
                if1.B_mat[e*8 +: 8] = 8'(v.b[e]);
            end else if (e < 4) begin
                if2.A_mat[e*4 +: 4] = 4'(v.a[e]);
                if2.B_mat[e*4 +: 4] = 4'(v.b[e]);
            end
        end
    endtask

    task automatic set_en(int inst, logic en);
        if0.enable = en && (inst == 0);
        if1.enable = en && (inst == 1);
        if2.enable = en && (inst == 2);
    endtask

    task automatic run_vec(vec_t v);
        int lat;
        lat = -1;
        @(negedge clk);
        drive(v);
        set_en(v.inst, 1'b1);
        @(posedge clk);
        #1;
        set_en(v.inst, 1'b0);
        check({v.name, " busy after start"}, int'(get_busy(v.inst)), 1);
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(posedge clk);
            #1;
            if (get_valid(v.inst)) lat = c;
        end
        check({v.name, " latency"}, lat, v.lat);
        if (lat >= 0) begin
            check_res(v.name, v.inst, v.c);
            check({v.name, " busy at valid"}, int'(get_busy(v.inst)), 0);
            @(posedge clk);
            #1;
            check({v.name, " valid width"}, int'(get_valid(v.inst)), 0);
            check_res({v.name, " hold"}, v.inst, v.c);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int zeros [16];
        int exp2 [16];
        int n_valid;
        int busy_low;

        for (int t = 0; t < NVEC; t++) begin
            tbl[t].inst = 0;
            tbl[t].lat  = 16;
            for (int e = 0; e < 16; e++) begin
                tbl[t].a[e] = 0;
                tbl[t].b[e] = 0;
                tbl[t].c[e] = 0;
            end
        end
        for (int e = 0; e < 16; e++) begin
            zeros[e] = 0;
            exp2[e]  = 255 * (24 + 4*(e%4));
            tbl[0].a[e] = (e/4 == e%4) ? 1 : 0;  tbl[0].b[e] = e;             tbl[0].c[e] = e;
            tbl[1].a[e] = 255;                   tbl[1].b[e] = 255;           tbl[1].c[e] = 260100;
            tbl[2].a[e] = 1;                     tbl[2].b[e] = e;             tbl[2].c[e] = 24 + 4*(e%4);
            tbl[3].a[e] = e;                     tbl[3].b[e] = (e/4 == e%4) ? 1 : 0;
            tbl[3].c[e] = e;
            tbl[4].a[e] = e/4 + 1;               tbl[4].b[e] = e/4 + e%4;
            tbl[4].c[e] = (e/4 + 1) * (6 + 4*(e%4));
            tbl[5].a[e] = 255;                   tbl[5].b[e] = 1;             tbl[5].c[e] = -4;
            tbl[6].a[e] = 128;                   tbl[6].b[e] = 128;           tbl[6].c[e] = 65536;
            tbl[8].a[e] = (e%2 == 0) ? 254 : 3;  tbl[8].b[e] = 5;             tbl[8].c[e] = 10;
        end
        tbl[0].name = "ident_ramp";
        tbl[1].name = "all_ff";
        tbl[2].name = "ones_ramp";
        tbl[3].name = "ramp_ident";
        tbl[4].name = "row_scaled";
        tbl[5].name = "s_neg1";     tbl[5].inst = 1;
        tbl[6].name = "s_min";      tbl[6].inst = 1;
        tbl[8].name = "s_mixed";    tbl[8].inst = 1;
        tbl[7].name = "n2_dw4";     tbl[7].inst = 2;  tbl[7].lat = 4;
        tbl[7].a[0] = 1; tbl[7].a[1] = 2; tbl[7].a[2] = 3; tbl[7].a[3] = 4;
        tbl[7].b[0] = 5; tbl[7].b[1] = 6; tbl[7].b[2] = 7; tbl[7].b[3] = 8;
        tbl[7].c[0] = 19; tbl[7].c[1] = 22; tbl[7].c[2] = 43; tbl[7].c[3] = 50;

        set_en(0, 1'b0);
        if0.A_mat = '0; if0.B_mat = '0;
        if1.A_mat = '0; if1.B_mat = '0;
        if2.A_mat = '0; if2.B_mat = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset valid", int'(if0.valid), 0);
        check("reset busy", int'(if0.busy), 0);
        check_res("reset", 0, zeros);
        check_res("reset n2", 2, zeros);
        @(negedge clk);
        reset = 1'b0;

        for (int t = 0; t < NVEC; t++) run_vec(tbl[t]);

        // Back-to-back runs with enable held high; A changes mid-run.
        @(negedge clk);
        drive(tbl[0]);
        set_en(0, 1'b1);
        @(posedge clk);
        n_valid  = 0;
        busy_low = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (c == 5) if0.A_mat = '1;
            if (!if0.busy) busy_low++;
            if (if0.valid) begin
                n_valid++;
                if (n_valid == 1) begin
                    check("b2b first at", c, 16);
                    check_res("b2b first", 0, tbl[0].c);
                end else if (n_valid == 2) begin
                    check("b2b second at", c, 34);
                    check_res("b2b second", 0, exp2);
                end else begin
                    check("b2b third at", c, 52);
                end
            end
        end
        check("b2b pulses", n_valid, 3);
        check("b2b busy low cycles", busy_low, 6);
        set_en(0, 1'b0);
        repeat (20) @(posedge clk);

        // Reset during the 8th CALC cycle.
        @(negedge clk);
        drive(tbl[0]);
        set_en(0, 1'b1);
        @(posedge clk);
        #1;
        set_en(0, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        check("progressive entry 5", get_res(0, 5), 5);
        check("busy before abort", int'(if0.busy), 1);
        #1;
        reset = 1'b1;
        #1;
        check("abort busy", int'(if0.busy), 0);
        check("abort valid", int'(if0.valid), 0);
        check_res("abort", 0, zeros);
        @(negedge clk);
        reset = 1'b0;
        n_valid = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            if (if0.valid || if0.busy) n_valid++;
        end
        check("no activity after abort", n_valid, 0);
        run_vec(tbl[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
